// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arbState_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arbOwner_e;

    function automatic int unsigned timer_width(input int unsigned limit);
        return (limit < 2) ? 1 : unsigned'($clog2(limit + 1));
    endfunction

endpackage

// File: rtl/mem_timeout_timer.sv
// Saturating wait-state counter; expired_o flags the cycle whose increment reaches LIMIT.
module mem_timeout_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned   CW   = timer_width(LIMIT);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Flag one cycle early so completion lands after exactly LIMIT stalled cycles.
    assign expired_o = en_i && (count_q >= LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory bus between fetch (I) and load/store (D) requesters.
// Optional round-robin tie breaking is enabled by defining ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,
    input  logic                    data_req_i,
    input  logic [DATA_WIDTH/8-1:0] data_we_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    output logic                    mem_req_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_ready_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned BW = DATA_WIDTH / 8;

    arbState_e             state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [BW-1:0]         mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic idle;
    logic pick_d;
    logic timer_expired;
    logic done;

    assign idle = (state_q == ARB_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    arbOwner_e last_owner_q, last_owner_d;

    assign pick_d = data_req_i && (!instr_req_i || (last_owner_q == OWNER_I));

    always_comb begin
        last_owner_d = last_owner_q;
        if (data_gnt_o) begin
            last_owner_d = OWNER_D;
        end else if (instr_gnt_o) begin
            last_owner_d = OWNER_I;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWNER_I;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign pick_d = data_req_i;
`endif

    // Grant depends only on registered state and requests, never on mem_ready_i.
    assign data_gnt_o  = idle && pick_d && !reset;
    assign instr_gnt_o = idle && instr_req_i && !pick_d && !reset;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            mem_timeout_timer #(
                .LIMIT(TIMEOUT_CYCLES)
            ) u_timer (
                .clk      (clk),
                .reset    (reset),
                .clr_i    (idle || mem_ready_i),
                .en_i     (!idle && !mem_ready_i),
                .expired_o(timer_expired)
            );
        end else begin : g_no_timer
            assign timer_expired = 1'b0;
        end
    endgenerate

    assign done = mem_ready_i || timer_expired;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rvalid_d  = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_rvalid_d  = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (data_gnt_o) begin
                    state_d     = ARB_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we_i;
                    mem_addr_d  = data_addr_i;
                    mem_wdata_d = data_wdata_i;
                end else if (instr_gnt_o) begin
                    state_d     = ARB_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = '0;
                    mem_addr_d  = instr_addr_i;
                    mem_wdata_d = '0;
                end
            end
            ARB_BUSY_I: begin
                if (done) begin
                    state_d    = ARB_IDLE;
                    mem_req_d  = 1'b0;
                    i_rvalid_d = 1'b1;
                    i_err_d    = !mem_ready_i;
                    i_rdata_d  = mem_ready_i ? mem_rdata_i : '0;
                end
            end
            ARB_BUSY_D: begin
                if (done) begin
                    state_d    = ARB_IDLE;
                    mem_req_d  = 1'b0;
                    d_rvalid_d = 1'b1;
                    d_err_d    = !mem_ready_i;
                    d_rdata_d  = (mem_ready_i && (mem_we_q == '0)) ? mem_rdata_i : '0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rvalid_q  <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign instr_rvalid_o = i_rvalid_q;
    assign instr_err_o    = i_err_q;
    assign instr_rdata_o  = i_rdata_q;
    assign data_rvalid_o  = d_rvalid_q;
    assign data_err_o     = d_err_q;
    assign data_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT_CYCLES=4); honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req, data_req;
    logic [31:0] instr_addr, data_addr, data_wdata;
    logic [3:0]  data_we;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    mem_port_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_req_i   (instr_req),
        .instr_addr_i  (instr_addr),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .data_req_i    (data_req),
        .data_we_i     (data_we),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ready_i   (mem_ready),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   ig_cyc[$];
    int   dg_cyc[$];
    bit   gnt_log[$];
    int   i_gnt_log[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h0000_0113;
    endfunction

    // Memory model: ready after mem_wait stalled cycles; -1 never answers.
    int mem_wait   = 0;
    bit late_ready = 1'b0;
    int busy_cnt   = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o) begin
                busy_cnt++;
                if (mem_wait >= 0 && busy_cnt == mem_wait + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_fn(mem_addr_o);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                busy_cnt  = 0;
                mem_ready = late_ready;
                mem_rdata = late_ready ? 32'h0000_1234 : 32'h0;
            end
        end
    end

    // Monitor: bus payload, grant rules and completions against the queues.
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_we;
    bit          exp_is_d;
    exp_t        e_mon;
    int          g_mon;

    always @(negedge clk) begin
        if (!reset) begin
            if (instr_gnt_o || data_gnt_o) begin
                chk("gnt_onehot", {31'b0, instr_gnt_o && data_gnt_o}, 32'd0);
                chk("gnt_when_idle", {31'b0, mem_req_o}, 32'd0);
                gnt_log.push_back(data_gnt_o);
                if (data_gnt_o) begin
                    exp_is_d  = 1'b1;
                    exp_addr  = data_addr;
                    exp_we    = data_we;
                    exp_wdata = data_wdata;
                    dg_cyc.push_back(cyc);
                end else begin
                    exp_is_d  = 1'b0;
                    exp_addr  = instr_addr;
                    exp_we    = 4'b0;
                    exp_wdata = 32'h0;
                    ig_cyc.push_back(cyc);
                    i_gnt_log.push_back(cyc);
                end
            end
            if (mem_req_o) begin
                chk("bus_addr", mem_addr_o, exp_addr);
                chk("bus_we", {28'b0, mem_we_o}, {28'b0, exp_we});
                if (exp_is_d) chk("bus_wdata", mem_wdata_o, exp_wdata);
            end
            if (instr_rvalid_o) begin
                if (iq.size() == 0 || ig_cyc.size() == 0) begin
                    chk("i_spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    e_mon = iq.pop_front();
                    g_mon = ig_cyc.pop_front();
                    chk("i_rdata", instr_rdata_o, e_mon.rdata);
                    chk("i_err", {31'b0, instr_err_o}, {31'b0, e_mon.err});
                    chk("i_latency", cyc - g_mon, e_mon.lat);
                end
            end
            if (data_rvalid_o) begin
                if (dq.size() == 0 || dg_cyc.size() == 0) begin
                    chk("d_spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    e_mon = dq.pop_front();
                    g_mon = dg_cyc.pop_front();
                    chk("d_rdata", data_rdata_o, e_mon.rdata);
                    chk("d_err", {31'b0, data_err_o}, {31'b0, e_mon.err});
                    chk("d_latency", cyc - g_mon, e_mon.lat);
                end
            end
        end
    end

    task automatic do_instr(input logic [31:0] addr, input int lat, input logic err);
        exp_t e;
        bit   got;
        e.rdata = err ? 32'h0 : mem_fn(addr);
        e.err   = err;
        e.lat   = lat;
        @(posedge clk);
        #1;
        instr_req  = 1'b1;
        instr_addr = addr;
        iq.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = instr_gnt_o;
        end
        if (!got) chk("i_gnt_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        instr_req = 1'b0;
    endtask

    task automatic do_data(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input logic err);
        exp_t e;
        bit   got;
        e.rdata = (err || we != 4'b0) ? 32'h0 : mem_fn(addr);
        e.err   = err;
        e.lat   = lat;
        @(posedge clk);
        #1;
        data_req   = 1'b1;
        data_we    = we;
        data_addr  = addr;
        data_wdata = wdata;
        dq.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = data_gnt_o;
        end
        if (!got) chk("d_gnt_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        data_req = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 200 && !empty; k++) begin
            @(posedge clk);
            empty = (iq.size() == 0) && (dq.size() == 0);
        end
        if (!empty) chk("drain_wait", 32'd0, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, {31'b0, mem_req_o}, 32'd0);
        chk({tag, "_mem_we"}, {28'b0, mem_we_o}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_gnts"}, {30'b0, instr_gnt_o, data_gnt_o}, 32'd0);
        chk({tag, "_rvalids"}, {28'b0, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}, 32'd0);
        chk({tag, "_rdatas"}, instr_rdata_o | data_rdata_o, 32'd0);
    endtask

    bit exp_order[3];

    initial begin
        reset      = 1'b1;
        instr_req  = 1'b1;
        data_req   = 1'b1;
        instr_addr = 32'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        data_we    = 4'b0;
        #2;
        chk_all_zero("reset");
        instr_req = 1'b0;
        data_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Simultaneous requests from idle: I holds one request, D issues two.
        mem_wait = 0;
        gnt_log.delete();
        fork
            do_instr(32'h0000_0300, 2, 1'b0);
            begin
                do_data(4'b0000, 32'h0000_3000, 32'h0, 2, 1'b0);
                do_data(4'b1111, 32'h0000_3004, 32'h1122_3344, 2, 1'b0);
            end
        join
        drain();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b0};
`endif
        chk("tie_count", gnt_log.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < gnt_log.size()) chk("tie_owner", {31'b0, gnt_log[k]}, {31'b0, exp_order[k]});
        end

        // Fetch with two wait states: rvalid four cycles after grant.
        mem_wait = 2;
        do_instr(32'h0000_0100, 4, 1'b0);
        drain();

        // Partial store with two wait states: rdata must read back zero.
        do_data(4'b0011, 32'h0000_2000, 32'h0000_AABB, 4, 1'b0);
        drain();

        // Streaming fetches at zero wait states.
        mem_wait = 0;
        i_gnt_log.delete();
        for (int k = 0; k < 4; k++) do_instr(32'h0000_0400 + 32'(k * 4), 2, 1'b0);
        drain();
        chk("stream_gnts", i_gnt_log.size(), 32'd4);
        for (int k = 1; k < i_gnt_log.size(); k++) chk("stream_gap", i_gnt_log[k] - i_gnt_log[k-1], 32'd2);

        // Timeout, then a late ready in idle, then a normal request.
        mem_wait = -1;
        do_data(4'b0000, 32'h0000_5000, 32'h0, TMO + 1, 1'b1);
        drain();
        late_ready = 1'b1;
        repeat (3) @(posedge clk);
        late_ready = 1'b0;
        repeat (2) @(posedge clk);
        mem_wait = 0;
        do_instr(32'h0000_0600, 2, 1'b0);
        drain();

        // Reset in the middle of a stalled load abandons it silently.
        mem_wait = -1;
        do_data(4'b0000, 32'h0000_6000, 32'h0, 99, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        dq.delete();
        dg_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_wait = 0;
        repeat (6) @(posedge clk);
        do_instr(32'h0000_0700, 2, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        chk("iq_left", iq.size(), 32'd0);
        chk("dq_left", dq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1);
    end

endmodule
